// File: rtl/axi_read_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axi_read_if                                           |
// | Purpose  : AXI-Lite read-channel bundle (AR + R) for axi_read     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
interface axi_read_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_prot;
  logic              ar_valid;
  logic              ar_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_valid;
  logic              r_ready;

  modport master (
    output ar_addr, ar_prot, ar_valid, r_ready,
    input  ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  ar_addr, ar_prot, ar_valid, r_ready,
    output ar_ready, r_data, r_resp, r_valid
  );
endinterface
`default_nettype wire

// File: rtl/axi_read.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axi_read                                              |
// | Purpose  : AXI-Lite single-word read master shared by maestro     |
// |            (high priority) and control FSM (low priority).        |
// | Option   : AXI_READ_ANTISTARVE_EN - bounded maestro streaks.      |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module axi_read #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // maestro requester
  input  logic [ADDR_W-1:0] maestro_adress_i,
  input  logic              maestro_req_i,
  output logic              maestro_ack_o,
  output logic [DATA_W-1:0] maestro_data_o,
  output logic              maestro_valid_o,
  output logic              maestro_err_o,
  // control FSM requester
  input  logic [ADDR_W-1:0] fsm_adress_i,
  input  logic              fsm_req_i,
  output logic              fsm_ack_o,
  output logic [DATA_W-1:0] fsm_data_o,
  output logic              fsm_valid_o,
  output logic              fsm_err_o,
  // AXI-Lite read channels
  axi_read_if.master        axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_grant_fsm;
  logic [ADDR_W-1:0] r_ar_addr;
  logic              r_ar_valid;
  logic              r_r_ready;

  logic              r_maestro_ack;
  logic              r_maestro_valid;
  logic              r_maestro_err;
  logic [DATA_W-1:0] r_maestro_data;
  logic              r_fsm_ack;
  logic              r_fsm_valid;
  logic              r_fsm_err;
  logic [DATA_W-1:0] r_fsm_data;

  logic              w_any_req;
  logic              w_pick_fsm;
  logic              w_r_fire;

  assign w_any_req = maestro_req_i | fsm_req_i;
  assign w_r_fire  = axi.r_valid & r_r_ready;

`ifdef AXI_READ_ANTISTARVE_EN
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_full;

  // Once the maestro has won STREAK_MAX times in a row against a waiting
  // FSM, the FSM takes the next contested slot.
  assign w_streak_full = (r_streak == STREAK_W'(STREAK_MAX));
  assign w_pick_fsm    = fsm_req_i & (~maestro_req_i | w_streak_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (r_state == IDLE && w_any_req) begin
      if (w_pick_fsm || !fsm_req_i) begin
        r_streak <= '0;
      end else begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  assign w_pick_fsm = fsm_req_i & ~maestro_req_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_grant_fsm     <= 1'b1;
      r_ar_addr       <= '0;
      r_ar_valid      <= 1'b0;
      r_r_ready       <= 1'b0;
      r_maestro_ack   <= 1'b0;
      r_maestro_valid <= 1'b0;
      r_maestro_err   <= 1'b0;
      r_maestro_data  <= '0;
      r_fsm_ack       <= 1'b0;
      r_fsm_valid     <= 1'b0;
      r_fsm_err       <= 1'b0;
      r_fsm_data      <= '0;
    end else begin
      r_maestro_ack   <= 1'b0;
      r_fsm_ack       <= 1'b0;
      r_maestro_valid <= 1'b0;
      r_fsm_valid     <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_fsm   <= w_pick_fsm;
            r_ar_addr     <= w_pick_fsm ? fsm_adress_i : maestro_adress_i;
            r_ar_valid    <= 1'b1;
            r_maestro_ack <= ~w_pick_fsm;
            r_fsm_ack     <= w_pick_fsm;
            r_state       <= ADDR;
          end
        end

        ADDR: begin
          if (axi.ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= DATA;
          end
        end

        DATA: begin
          // Only the granted requester's result registers move; the other
          // side keeps its last completion.
          if (w_r_fire) begin
            if (r_grant_fsm) begin
              r_fsm_data  <= axi.r_data;
              r_fsm_err   <= axi.r_resp[1];
              r_fsm_valid <= 1'b1;
            end else begin
              r_maestro_data  <= axi.r_data;
              r_maestro_err   <= axi.r_resp[1];
              r_maestro_valid <= 1'b1;
            end
            r_r_ready <= 1'b0;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_ar_valid <= 1'b0;
          r_r_ready  <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign axi.ar_addr  = r_ar_addr;
  assign axi.ar_prot  = 3'b000;
  assign axi.ar_valid = r_ar_valid;
  assign axi.r_ready  = r_r_ready;

  assign maestro_ack_o   = r_maestro_ack;
  assign maestro_data_o  = r_maestro_data;
  assign maestro_valid_o = r_maestro_valid;
  assign maestro_err_o   = r_maestro_err;
  assign fsm_ack_o       = r_fsm_ack;
  assign fsm_data_o      = r_fsm_data;
  assign fsm_valid_o     = r_fsm_valid;
  assign fsm_err_o       = r_fsm_err;

  // r_resp[0] only separates OKAY/EXOKAY and SLVERR/DECERR; bit 1 flags errors.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, axi.r_resp[0], (STREAK_MAX != 0)};

endmodule
`default_nettype wire

// File: tb/tb_axi_read.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_axi_read                                           |
// | Purpose  : Scoreboard bench for axi_read (honours                 |
// |            AXI_READ_ANTISTARVE_EN when defined).                  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_axi_read;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;
  localparam logic [31:0] XOR_KEY = 32'hDEAD_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] maestro_adress_i, fsm_adress_i;
  logic              maestro_req_i, fsm_req_i;
  logic              maestro_ack_o, maestro_valid_o, maestro_err_o;
  logic              fsm_ack_o, fsm_valid_o, fsm_err_o;
  logic [DATA_W-1:0] maestro_data_o, fsm_data_o;

  axi_read_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_read #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .maestro_adress_i (maestro_adress_i),
    .maestro_req_i    (maestro_req_i),
    .maestro_ack_o    (maestro_ack_o),
    .maestro_data_o   (maestro_data_o),
    .maestro_valid_o  (maestro_valid_o),
    .maestro_err_o    (maestro_err_o),
    .fsm_adress_i     (fsm_adress_i),
    .fsm_req_i        (fsm_req_i),
    .fsm_ack_o        (fsm_ack_o),
    .fsm_data_o       (fsm_data_o),
    .fsm_valid_o      (fsm_valid_o),
    .fsm_err_o        (fsm_err_o),
    .axi              (bus)
  );

  // Slave model: manual data/resp, or data derived from the accepted address.
  logic        ar_ready_drv, r_valid_drv, auto_mode;
  logic [31:0] man_data, last_addr;
  logic [1:0]  man_resp;
  assign bus.ar_ready = ar_ready_drv;
  assign bus.r_valid  = r_valid_drv;
  assign bus.r_data   = auto_mode ? (last_addr ^ XOR_KEY) : man_data;
  assign bus.r_resp   = auto_mode ? 2'b00 : man_resp;
  always @(posedge clk) if (bus.ar_valid && bus.ar_ready) last_addr <= bus.ar_addr;

  typedef struct packed {
    logic        is_fsm;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    if (rst_n && (maestro_valid_o || fsm_valid_o)) begin
      n_checks++;
      mon_a = {fsm_valid_o, fsm_valid_o ? fsm_data_o : maestro_data_o,
               fsm_valid_o ? fsm_err_o : maestro_err_o};
      if (maestro_valid_o && fsm_valid_o) begin
        n_fail++;
        $display("FAIL scoreboard_both_valid: got both valid pulses, required one");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got fsm=%0b data=%h err=%0b, required no completion",
                 mon_a.is_fsm, mon_a.data, mon_a.err);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard: got fsm=%0b data=%h err=%0b, required fsm=%0b data=%h err=%0b",
                   mon_a.is_fsm, mon_a.data, mon_a.err, mon_e.is_fsm, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.ar_valid, bus.r_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_axi_ctrl: got %b, required 00", {bus.ar_valid, bus.r_ready});
    end
    n_checks++;
    if ({bus.ar_addr, bus.ar_prot} !== 35'd0) begin
      n_fail++; $display("FAIL reset_ar_addr: got %h prot %b, required 0", bus.ar_addr, bus.ar_prot);
    end
    n_checks++;
    if ({maestro_ack_o, maestro_valid_o, maestro_err_o, fsm_ack_o, fsm_valid_o, fsm_err_o} !== 6'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000",
        {maestro_ack_o, maestro_valid_o, maestro_err_o, fsm_ack_o, fsm_valid_o, fsm_err_o});
    end
    n_checks++;
    if ({maestro_data_o, fsm_data_o} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h, required 0", maestro_data_o, fsm_data_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fsm_single();
    logic got = 1'b0;
    ar_ready_drv = 1'b1; r_valid_drv = 1'b1; auto_mode = 1'b0;
    man_data = 32'hCAFE_0001; man_resp = 2'b00;
    fsm_adress_i = 32'h0000_0040; fsm_req_i = 1'b1;
    exp_q.push_back({1'b1, 32'hCAFE_0001, 1'b0});
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = fsm_ack_o; end
    n_checks++;
    if ({got, maestro_ack_o} !== 2'b10) begin
      n_fail++; $display("FAIL fsm_ack: got fsm_ack=%b maestro_ack=%b, required 1 0", got, maestro_ack_o);
    end
    n_checks++;
    if ({bus.ar_valid, bus.ar_addr} !== {1'b1, 32'h0000_0040}) begin
      n_fail++; $display("FAIL fsm_ar: got valid=%b addr=%h, required 1 00000040", bus.ar_valid, bus.ar_addr);
    end
    fsm_req_i = 1'b0;
    tick(); tick();
    n_checks++;
    if ({fsm_valid_o, fsm_data_o, fsm_err_o} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
      n_fail++; $display("FAIL fsm_latency: got valid=%b data=%h err=%b, required 1 cafe0001 0",
                         fsm_valid_o, fsm_data_o, fsm_err_o);
    end
    tick();
    n_checks++;
    if ({fsm_valid_o, fsm_data_o} !== {1'b0, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL fsm_pulse_hold: got valid=%b data=%h, required 0 cafe0001", fsm_valid_o, fsm_data_o);
    end
    wait_drain(10);
  endtask

  task automatic test_priority();
    int k = 0;
    logic got = 1'b0;
    auto_mode = 1'b1;
    maestro_adress_i = 32'h100; fsm_adress_i = 32'h200;
    exp_q.push_back({1'b0, 32'h100 ^ XOR_KEY, 1'b0});
    exp_q.push_back({1'b1, 32'h200 ^ XOR_KEY, 1'b0});
    maestro_req_i = 1'b1; fsm_req_i = 1'b1;
    tick();
    n_checks++;
    if ({maestro_ack_o, fsm_ack_o, bus.ar_addr} !== {2'b10, 32'h100}) begin
      n_fail++; $display("FAIL prio_first: got m=%b f=%b addr=%h, required 1 0 00000100",
                         maestro_ack_o, fsm_ack_o, bus.ar_addr);
    end
    maestro_req_i = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); k++; got = fsm_ack_o; end
    n_checks++;
    if ({got, k[3:0], bus.ar_addr} !== {1'b1, 4'd3, 32'h200}) begin
      n_fail++; $display("FAIL prio_second: got ack=%b after %0d cycles addr=%h, required 1 after 3 addr 00000200",
                         got, k, bus.ar_addr);
    end
    fsm_req_i = 1'b0;
    wait_drain(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL prio_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_ar_stall();
    logic got = 1'b0;
    ar_ready_drv = 1'b0; auto_mode = 1'b1;
    maestro_adress_i = 32'h300; maestro_req_i = 1'b1;
    exp_q.push_back({1'b0, 32'h300 ^ XOR_KEY, 1'b0});
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = maestro_ack_o; end
    maestro_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({bus.ar_valid, bus.r_ready, bus.ar_addr} !== {2'b10, 32'h300}) begin
        n_fail++; $display("FAIL stall_cycle%0d: got valid=%b rready=%b addr=%h, required 1 0 00000300",
                           i, bus.ar_valid, bus.r_ready, bus.ar_addr);
      end
      if (i < 5) tick();
    end
    ar_ready_drv = 1'b1;
    tick();
    n_checks++;
    if ({bus.ar_valid, bus.r_ready} !== 2'b01) begin
      n_fail++; $display("FAIL stall_release: got valid=%b rready=%b, required 0 1", bus.ar_valid, bus.r_ready);
    end
    wait_drain(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_error_resp();
    logic got = 1'b0;
    auto_mode = 1'b0; man_data = 32'h0000_1234; man_resp = 2'b10;
    maestro_adress_i = 32'h400; maestro_req_i = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_1234, 1'b1});
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = maestro_ack_o; end
    maestro_req_i = 1'b0;
    wait_drain(10);
    n_checks++;
    if ({maestro_data_o, maestro_err_o} !== {32'h0000_1234, 1'b1}) begin
      n_fail++; $display("FAIL err_maestro: got data=%h err=%b, required 00001234 1", maestro_data_o, maestro_err_o);
    end
    n_checks++;
    if ({fsm_data_o, fsm_err_o} !== {32'h200 ^ XOR_KEY, 1'b0}) begin
      n_fail++; $display("FAIL err_fsm_untouched: got data=%h err=%b, required %h 0",
                         fsm_data_o, fsm_err_o, 32'h200 ^ XOR_KEY);
    end
    man_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic got  = 1'b0;
    logic seen = 1'b0;
    auto_mode = 1'b1; ar_ready_drv = 1'b1; r_valid_drv = 1'b0;
    maestro_adress_i = 32'h500; maestro_req_i = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin tick(); got = maestro_ack_o; end
    maestro_req_i = 1'b0;
    tick();
    n_checks++;
    if ({bus.ar_valid, bus.r_ready} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_in_data: got valid=%b rready=%b, required 0 1", bus.ar_valid, bus.r_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.ar_valid, bus.r_ready, maestro_valid_o, fsm_valid_o, maestro_data_o} !== 36'd0) begin
      n_fail++; $display("FAIL midrst_async: got valid=%b rready=%b mv=%b fv=%b mdata=%h, required all 0",
                         bus.ar_valid, bus.r_ready, maestro_valid_o, fsm_valid_o, maestro_data_o);
    end
    r_valid_drv = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | maestro_valid_o | fsm_valid_o | bus.ar_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_completion: got activity=%b, required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_fsm [6];
    int g = 0;
`ifdef AXI_READ_ANTISTARVE_EN
    exp_fsm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_fsm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    auto_mode = 1'b1; ar_ready_drv = 1'b1; r_valid_drv = 1'b1;
    maestro_adress_i = 32'h600; fsm_adress_i = 32'h700;
    maestro_req_i = 1'b1; fsm_req_i = 1'b1;
    for (int i = 0; i < 80 && g < 6; i++) begin
      tick();
      if (maestro_ack_o || fsm_ack_o) begin
        n_checks++;
        if ({fsm_ack_o, maestro_ack_o} !== {exp_fsm[g], ~exp_fsm[g]}) begin
          n_fail++; $display("FAIL b2b_grant%0d: got fsm_ack=%b maestro_ack=%b, required fsm=%b",
                             g, fsm_ack_o, maestro_ack_o, exp_fsm[g]);
        end
        exp_q.push_back({exp_fsm[g], (exp_fsm[g] ? 32'h700 : 32'h600) ^ XOR_KEY, 1'b0});
        g++;
        if (g == 6) begin maestro_req_i = 1'b0; fsm_req_i = 1'b0; end
      end
    end
    maestro_req_i = 1'b0; fsm_req_i = 1'b0;
    n_checks++;
    if (g != 6) begin
      n_fail++; $display("FAIL b2b_grant_count: got %0d grants, required 6", g);
    end
    wait_drain(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    maestro_adress_i = '0; fsm_adress_i = '0;
    maestro_req_i = 1'b0;  fsm_req_i = 1'b0;
    ar_ready_drv = 1'b0;   r_valid_drv = 1'b0; auto_mode = 1'b0;
    man_data = '0;         man_resp = 2'b00;   last_addr = '0;
    test_reset();
    test_fsm_single();
    test_priority();
    test_ar_stall();
    test_error_resp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/axi_read.md
Name: axi_read

Overview:
- AXI-Lite read master shared by two requesters: maestro (high priority) and control FSM (low priority).
- Arbitrates single-word read requests and drives the AR/R channels, one outstanding transaction at a time.
- Returns read data, a valid pulse and an error flag to the granted requester.
- Read-side companion of the AXI-Lite write path; sits between the maestro/FSM control logic and the AXI-Lite interconnect.

Parameters:
ADDR_W, 32, address width of requester inputs and ar_addr
DATA_W, 32, data width of r_data and requester data outputs
STREAK_MAX, 4, consecutive maestro grants allowed while fsm waits (used only with optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
maestro_adress_i  in  ADDR_W  maestro read address
maestro_req_i  in  1  maestro request, level
maestro_ack_o  out  1  one-cycle pulse: maestro request accepted
maestro_data_o  out  DATA_W  read data for maestro
maestro_valid_o  out  1  one-cycle pulse: maestro_data_o/maestro_err_o valid
maestro_err_o  out  1  response was SLVERR/DECERR
fsm_adress_i  in  ADDR_W  FSM read address
fsm_req_i  in  1  FSM request, level
fsm_ack_o  out  1  one-cycle pulse: FSM request accepted
fsm_data_o  out  DATA_W  read data for FSM
fsm_valid_o  out  1  one-cycle pulse: fsm_data_o/fsm_err_o valid
fsm_err_o  out  1  response was SLVERR/DECERR
ar_addr  out  ADDR_W  AXI read address
ar_prot  out  3  tied 3'b000
ar_valid  out  1  AXI address valid
ar_ready  in  1  AXI address ready
r_data  in  DATA_W  AXI read data
r_resp  in  2  AXI read response
r_valid  in  1  AXI read data valid
r_ready  out  1  AXI read data ready

Behaviour:
- Clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; ar_valid=0, r_ready=0, ar_addr=0.
- Reset values (requester side): all ack/valid/err outputs 0, data outputs 0, grant register = fsm, streak counter 0.
- All outputs are registered.
- IDLE: requests are sampled only in this state.
  - If maestro_req_i, grant maestro; else if fsm_req_i, grant FSM.
  - On grant: ar_addr <= granted address, ar_valid <= 1, granted ack_o pulses for 1 cycle, go ADDR.
- ADDR: ar_valid and ar_addr are held stable until ar_ready=1 is sampled.
  - On that edge: ar_valid <= 0, r_ready <= 1, go DATA.
  - No timeout; ar_ready may stay low indefinitely.
- DATA: on r_valid & r_ready:
  - granted data_o <= r_data; granted err_o <= r_resp[1]; granted valid_o pulses 1 cycle.
  - r_ready <= 0, go IDLE.
  - The other requester's data/err outputs are unchanged.
- r_valid while not in DATA is ignored, since r_ready=0.
- Data and err outputs hold their value until the next completion for the same requester.
- Minimum latency: request sampled at edge N, ar_valid high after N; with ar_ready and r_valid already high, valid_o pulses after edge N+2.
  - Next grant occurs no earlier than edge N+3 (IDLE lasts at least 1 cycle).
- Requester rules:
  - Hold req and address stable until ack.
  - Deassert req the cycle after ack; a req still high when the block returns to IDLE is a new read.
  - Dropping req before ack is legal; it has no effect unless sampled in IDLE.
- Simultaneous requests: maestro wins. The FSM request stays pending and is served in the next IDLE with no maestro request.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight transaction is abandoned with no valid_o.

Optional Feature:
- Macro AXI_READ_ANTISTARVE_EN.
- Defined:
  - Streak counter increments on each maestro grant made while fsm_req_i=1.
  - Counter clears on any FSM grant, and on a maestro grant made while fsm_req_i=0.
  - When counter == STREAK_MAX and both requests are high, the FSM is granted.
- Undefined: strict maestro priority; counter logic is absent. FSM may starve.

Test Plan:
- FSM alone reads 0x0000_0040 (ar_ready=1, r_valid=1 immediate, r_data=0xCAFE_0001, r_resp=0) -> fsm_ack_o pulse, ar_addr=0x40, fsm_valid_o 2 cycles after ack, fsm_data_o=0xCAFE_0001, fsm_err_o=0.
- Maestro and FSM request same cycle (0x100, 0x200) -> maestro served first with ar_addr=0x100; FSM served next with ar_addr=0x200; each valid_o matches its own data.
- ar_ready held low 5 cycles -> ar_valid and ar_addr stable for 6 cycles, r_ready=0 throughout; then normal completion.
- r_resp=2'b10 with r_data=0x1234 -> maestro_valid_o pulse, maestro_err_o=1, maestro_data_o=0x1234; FSM outputs unchanged.
- rst_n low while in DATA -> ar_valid, r_ready, all valid_o 0 asynchronously; no completion pulse after release.
- With AXI_READ_ANTISTARVE_EN and STREAK_MAX=4, both requests held high -> grant order M,M,M,M,F,M...; without macro -> only M is granted.
